// File: rtl/pe_column_param.sv
// +-----------------------------------------------------------------------------+
// | pe_column_param: systolic MAC column, skewed psum capture, 2-entry out queue |
// | Optional: `define PE_SATURATE_EN for saturating MAC.  Rev 1.0                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pe_column_param #(
  parameter int ROWS       = 8,
  parameter int DATA_WIDTH = 16,
  parameter int OUTPUT_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  output logic                       clr_o,
  input  logic                       we_i,
  output logic                       we_o,
  input  logic [ROWS*DATA_WIDTH-1:0] srca_word_i,
  output logic [ROWS*DATA_WIDTH-1:0] srca_word_o,
  input  logic [DATA_WIDTH-1:0]      srcb_i,
  output logic [ROWS*DATA_WIDTH-1:0] wordp_o,
  output logic                       wordp_valid_o,
  input  logic                       wordp_ready_i,
  output logic                       ovf_o
);

  localparam int WORD_W  = ROWS * DATA_WIDTH;
  localparam int CHAIN_W = ROWS + OUTPUT_LAT - 1;

  logic [DATA_WIDTH-1:0] b_q     [1:ROWS-1];
  logic [ROWS-1:1]       clr_q;
  logic [DATA_WIDTH-1:0] b_row   [ROWS];
  logic [ROWS-1:0]       clr_row;
  logic [DATA_WIDTH-1:0] psum_q  [ROWS];
  logic [DATA_WIDTH-1:0] psum_d  [ROWS];
  logic [WORD_W-1:0]     srca_q;
  logic [CHAIN_W-1:0]    we_chain_q;
  logic [CHAIN_W:0]      we_tap;
  logic [WORD_W-1:0]     stage_word;

  logic [WORD_W-1:0]     q0_q, q0_d, q1_q, q1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 1; r < ROWS; r++) b_q[r] <= '0;
      clr_q  <= '0;
      srca_q <= '0;
    end else begin
      b_q[1]   <= srcb_i;
      clr_q[1] <= clr_i;
      for (int r = 2; r < ROWS; r++) begin
        b_q[r]   <= b_q[r-1];
        clr_q[r] <= clr_q[r-1];
      end
      srca_q <= srca_word_i;
    end
  end

  // Tap k of the we chain is we_i delayed k cycles; tap 0 is we_i itself.
  assign we_tap = {we_chain_q, we_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) we_chain_q <= '0;
    else       we_chain_q <= we_tap[CHAIN_W-1:0];
  end

  genvar r;
  generate
    for (r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_WIDTH-1:0] a_lane;
      logic [DATA_WIDTH-1:0] base;
      logic [DATA_WIDTH-1:0] prod;

      if (r == 0) begin : g_head
        assign b_row[r]   = srcb_i;
        assign clr_row[r] = clr_i;
      end else begin : g_skew
        assign b_row[r]   = b_q[r];
        assign clr_row[r] = clr_q[r];
      end

      assign a_lane = srca_word_i[r*DATA_WIDTH +: DATA_WIDTH];
      assign base   = clr_row[r] ? '0 : psum_q[r];

`ifdef PE_SATURATE_EN
      localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      logic [2*DATA_WIDTH-1:0] prod_full;
      logic [DATA_WIDTH:0]     sum_full;

      assign prod_full = $signed({{DATA_WIDTH{a_lane[DATA_WIDTH-1]}}, a_lane}) *
                         $signed({{DATA_WIDTH{b_row[r][DATA_WIDTH-1]}}, b_row[r]});
      // Product fits when the top DATA_WIDTH+1 bits are all sign copies.
      assign prod = (&prod_full[2*DATA_WIDTH-1:DATA_WIDTH-1] ||
                     ~|prod_full[2*DATA_WIDTH-1:DATA_WIDTH-1]) ? prod_full[DATA_WIDTH-1:0] :
                    (prod_full[2*DATA_WIDTH-1] ? SAT_MIN : SAT_MAX);
      assign sum_full  = {base[DATA_WIDTH-1], base} + {prod[DATA_WIDTH-1], prod};
      assign psum_d[r] = (sum_full[DATA_WIDTH] == sum_full[DATA_WIDTH-1]) ?
                         sum_full[DATA_WIDTH-1:0] :
                         (sum_full[DATA_WIDTH] ? SAT_MIN : SAT_MAX);
`else
      assign prod      = a_lane * b_row[r];
      assign psum_d[r] = base + prod;
`endif

      // Lane r is captured r cycles after lane 0, so each lane waits in a
      // delay line until the last lane lands; successive words never collide.
      if (r < ROWS - 1) begin : g_deskew
        localparam int DEPTH = ROWS - 1 - r;
        logic [DATA_WIDTH-1:0] dly_q [DEPTH];

        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            for (int j = 0; j < DEPTH; j++) dly_q[j] <= '0;
          end else begin
            if (we_tap[OUTPUT_LAT + r]) dly_q[0] <= psum_q[r];
            for (int j = 1; j < DEPTH; j++) dly_q[j] <= dly_q[j-1];
          end
        end

        assign stage_word[r*DATA_WIDTH +: DATA_WIDTH] = dly_q[DEPTH-1];
      end else begin : g_tail
        assign stage_word[r*DATA_WIDTH +: DATA_WIDTH] = psum_q[r];
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < ROWS; k++) psum_q[k] <= '0;
    end else begin
      for (int k = 0; k < ROWS; k++) psum_q[k] <= psum_d[k];
    end
  end

  assign push          = we_tap[CHAIN_W];
  assign wordp_valid_o = (cnt_q != 2'd0);
  assign pop           = wordp_valid_o & wordp_ready_i;

  always_comb begin
    q0_d  = q0_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push && pop) begin
      if (cnt_q == 2'd1) begin
        q0_d = stage_word;
      end else begin
        q0_d = q1_q;
        q1_d = stage_word;
      end
    end else if (push) begin
      case (cnt_q)
        2'd0: begin
          q0_d  = stage_word;
          cnt_d = 2'd1;
        end
        2'd1: begin
          q1_d  = stage_word;
          cnt_d = 2'd2;
        end
        default: ovf_d = 1'b1;
      endcase
    end else if (pop) begin
      q0_d  = q1_q;
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q0_q  <= '0;
      q1_q  <= '0;
      cnt_q <= 2'd0;
      ovf_q <= 1'b0;
    end else begin
      q0_q  <= q0_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign clr_o       = clr_q[1];
  assign we_o        = we_chain_q[0];
  assign srca_word_o = srca_q;
  assign wordp_o     = wordp_valid_o ? q0_q : '0;
  assign ovf_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_column_param.sv
// +-----------------------------------------------------------------------------+
// | tb_pe_column_param: random + directed bench against a behavioural model      |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_pe_column_param;

  localparam int ROWS = 8;
  localparam int DW   = 16;
  localparam int WW   = ROWS * DW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          we_i  = 1'b0;
  logic          wordp_ready_i = 1'b0;
  logic [WW-1:0] srca_word_i = '0;
  logic [DW-1:0] srcb_i = '0;
  logic          clr_o, we_o, wordp_valid_o, ovf_o;
  logic [WW-1:0] srca_word_o, wordp_o;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [DW-1:0] psum_m [ROWS];
  logic [DW-1:0] b_h    [32];
  bit            clr_h  [32];
  bit            we_h   [32];
  logic [WW-1:0] acc_h  [32];
  logic [WW-1:0] mq [$];
  bit            ovf_m;
  logic [WW-1:0] srca_m;
  bit            clr_m, we_m;
  int            mc;

  pe_column_param #(.ROWS(ROWS), .DATA_WIDTH(DW), .OUTPUT_LAT(1)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (clr_i),
    .clr_o         (clr_o),
    .we_i          (we_i),
    .we_o          (we_o),
    .srca_word_i   (srca_word_i),
    .srca_word_o   (srca_word_o),
    .srcb_i        (srcb_i),
    .wordp_o       (wordp_o),
    .wordp_valid_o (wordp_valid_o),
    .wordp_ready_i (wordp_ready_i),
    .ovf_o         (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] rep(input logic [DW-1:0] v);
    return {ROWS{v}};
  endfunction

  function automatic int clamp(input int x);
`ifdef PE_SATURATE_EN
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
`endif
    return x;
  endfunction

  function automatic logic [DW-1:0] mac(input logic [DW-1:0] base, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    int p, s;
    p = clamp(int'($signed(a)) * int'($signed(b)));
    s = clamp(int'($signed(base)) + p);
    return s[DW-1:0];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) psum_m[r] = '0;
    for (int i = 0; i < 32; i++) begin
      b_h[i] = '0; clr_h[i] = 0; we_h[i] = 0; acc_h[i] = '0;
    end
    mq.delete();
    ovf_m = 0; srca_m = '0; clr_m = 0; we_m = 0; mc = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic [WW-1:0] push_w;
    bit push;
    push   = 0;
    push_w = '0;
    b_h[mc % 32]   = srcb_i;
    clr_h[mc % 32] = clr_i;
    we_h[mc % 32]  = we_i;
    // A word started by we at cycle k takes lane r from psum_r as held in cycle k+1+r.
    for (int r = 0; r < ROWS; r++) begin
      int k;
      k = mc - 1 - r;
      if (k >= 0 && we_h[k % 32]) begin
        acc_h[k % 32][r*DW +: DW] = psum_m[r];
        if (r == ROWS - 1) begin
          push   = 1;
          push_w = acc_h[k % 32];
        end
      end
    end
    if (mq.size() != 0 && wordp_ready_i) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < 2) mq.push_back(push_w);
      else               ovf_m = 1;
    end
    for (int r = 0; r < ROWS; r++) begin
      int i;
      logic [DW-1:0] bb;
      bit cc;
      i  = mc - r;
      bb = '0;
      cc = 0;
      if (i >= 0) begin
        bb = b_h[i % 32];
        cc = clr_h[i % 32];
      end
      psum_m[r] = mac(cc ? '0 : psum_m[r], srca_word_i[r*DW +: DW], bb);
    end
    srca_m = srca_word_i;
    clr_m  = clr_i;
    we_m   = we_i;
    mc++;
  endtask

  task automatic compare();
    logic [WW-1:0] exp_w;
    exp_w = (mq.size() != 0) ? mq[0] : '0;
    chk("valid",  wordp_valid_o, mq.size() != 0);
    chk("word",   wordp_o, exp_w);
    chk("ovf",    ovf_o, ovf_m);
    chk("srca_o", srca_word_o, srca_m);
    chk("clr_o",  clr_o, clr_m);
    chk("we_o",   we_o, we_m);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_i);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    compare();
  endtask

  task automatic idle_inputs();
    clr_i  = 1'b0;
    we_i   = 1'b0;
    srcb_i = '0;
  endtask

  task automatic pulse_word(input logic [DW-1:0] b);
    srcb_i = b;
    clr_i  = 1'b1;
    we_i   = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    int first;
    logic [WW-1:0] exp_w;

    idle_inputs();
    do_reset();
    chk("rst_valid", wordp_valid_o, 1'b0);
    chk("rst_word",  wordp_o, '0);
    chk("rst_ovf",   ovf_o, 1'b0);

    // Four-term accumulation, latency of first valid
    srca_word_i = rep(16'd1);
    for (int i = 0; i < 4; i++) begin
      srcb_i = 16'd2;
      clr_i  = (i == 0);
      we_i   = (i == 3);
      step();
    end
    idle_inputs();
    first = (wordp_valid_o === 1'b1) ? 1 : 0;
    for (int n = 2; n <= 12; n++) begin
      step();
      if (first == 0 && wordp_valid_o === 1'b1) first = n;
    end
    chk("t1_latency", first, 9);
    chk("t1_word", wordp_o, rep(16'h0008));
    chk("t1_ovf", ovf_o, 1'b0);
    wordp_ready_i = 1'b1;
    step();
    wordp_ready_i = 1'b0;
    chk("t1_drain", wordp_valid_o, 1'b0);

    // Lane-dependent single product
    for (int r = 0; r < ROWS; r++) srca_word_i[r*DW +: DW] = DW'(r);
    pulse_word(16'd3);
    repeat (9) step();
    exp_w = '0;
    for (int r = 0; r < ROWS; r++) exp_w[r*DW +: DW] = DW'(3 * r);
    chk("t2_word", wordp_o, exp_w);
    wordp_ready_i = 1'b1;
    step();
    wordp_ready_i = 1'b0;

    // Overflowing product and negative operands
    srca_word_i = rep(16'h4000);
    pulse_word(16'd2);
    repeat (9) step();
`ifdef PE_SATURATE_EN
    chk("t3_sat", wordp_o, rep(16'h7FFF));
`else
    chk("t3_wrap", wordp_o, rep(16'h8000));
`endif
    wordp_ready_i = 1'b1;
    step();
    wordp_ready_i = 1'b0;
    srca_word_i = rep(16'hFFFF);
    pulse_word(16'hFFFF);
    repeat (9) step();
    chk("t3_neg", wordp_o, rep(16'h0001));
    wordp_ready_i = 1'b1;
    step();
    wordp_ready_i = 1'b0;

    // Three back-to-back words into a stalled queue
    do_reset();
    srca_word_i = rep(16'd1);
    for (int k = 0; k < 3; k++) begin
      srcb_i = DW'(5 + k);
      clr_i  = 1'b1;
      we_i   = 1'b1;
      step();
    end
    idle_inputs();
    repeat (12) step();
    chk("t4_ovf", ovf_o, 1'b1);
    chk("t4_head1", wordp_o, rep(16'd5));
    wordp_ready_i = 1'b1;
    step();
    chk("t4_head2", wordp_o, rep(16'd6));
    step();
    chk("t4_empty", wordp_valid_o, 1'b0);
    wordp_ready_i = 1'b0;

    // Pop on the same edge a third word lands in a full queue
    do_reset();
    srca_word_i = rep(16'd1);
    for (int i = 0; i < 15; i++) begin
      srcb_i        = (i < 3) ? DW'(5 + i) : '0;
      clr_i         = (i < 3);
      we_i          = (i < 3);
      wordp_ready_i = (i == 10);
      step();
    end
    idle_inputs();
    chk("t5_ovf", ovf_o, 1'b0);
    chk("t5_head", wordp_o, rep(16'd6));
    wordp_ready_i = 1'b1;
    step();
    chk("t5_second", wordp_o, rep(16'd7));
    step();
    chk("t5_empty", wordp_valid_o, 1'b0);
    wordp_ready_i = 1'b0;

    // Asynchronous reset mid-computation
    do_reset();
    srca_word_i = rep(16'd1);
    pulse_word(16'd2);
    srcb_i = 16'd9;
    clr_i  = 1'b1;
    repeat (3) step();
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    chk("t6_valid", wordp_valid_o, 1'b0);
    chk("t6_word",  wordp_o, '0);
    chk("t6_ovf",   ovf_o, 1'b0);
    chk("t6_clr_o", clr_o, 1'b0);
    chk("t6_we_o",  we_o, 1'b0);
    chk("t6_srca",  srca_word_o, '0);
    idle_inputs();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    compare();
    first = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (wordp_valid_o !== 1'b0) first = 1;
    end
    chk("t6_noword", first, 0);
    pulse_word(16'd4);
    repeat (9) step();
    chk("t6_fresh", wordp_o, rep(16'd4));
    wordp_ready_i = 1'b1;
    step();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      srca_word_i   = {$urandom, $urandom, $urandom, $urandom};
      srcb_i        = DW'($urandom);
      clr_i         = ($urandom_range(0, 3) == 0);
      we_i          = ($urandom_range(0, 2) == 0);
      wordp_ready_i = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
      step();
    end
    idle_inputs();
    wordp_ready_i = 1'b1;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
